// File: rtl/led_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pkg -- shared scan-state and pixel-frame types for the LED matrix path
// Rev 1.0
// ---------------------------------------------------------------------------
package led_pkg;

  localparam int ROWS_DEF = 16;
  localparam int COLS_DEF = 16;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_t;

  typedef logic [15:0][15:0] pixel_frame_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_timer -- loadable down-counter; done flags the last cycle of a phase
// Rev 1.0
// ---------------------------------------------------------------------------
module scan_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_matrix_scanner -- row-multiplexed bi-colour LED scan with frame shadowing
// Rev 1.0
// ---------------------------------------------------------------------------
module led_matrix_scanner
  import led_pkg::*;
#(
  parameter int ROWS         = ROWS_DEF,
  parameter int COLS         = COLS_DEF,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [ROWS-1:0][COLS-1:0]  RedPixels,
  input  logic [ROWS-1:0][COLS-1:0]  GrnPixels,
  output logic [ROWS-1:0]            RowSinks,
  output logic [COLS-1:0]            RedDriver,
  output logic [COLS-1:0]            GrnDriver,
  output logic                       frame_start
);

  localparam int CW = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam int RW = $clog2(ROWS);

  // Timer is loaded with length-1 so that done marks the final cycle of a phase.
  localparam logic [CW-1:0] DWELL_LOAD     = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LOAD     = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ROW_START_LOAD = (BLANK_CYCLES == 0) ? DWELL_LOAD : BLANK_LOAD;
  localparam logic [RW-1:0] LAST_ROW       = RW'(ROWS - 1);

  scan_state_t               state;
  logic [RW-1:0]             row;
  logic [RW-1:0]             row_next;
  logic                      last_row;
  logic [ROWS-1:0][COLS-1:0] shadow_red;
  logic [ROWS-1:0][COLS-1:0] shadow_grn;
  logic                      timer_load;
  logic [CW-1:0]             timer_value;
  logic                      timer_tick;
  logic                      timer_done;

  function automatic logic [ROWS-1:0] row_select(input logic [RW-1:0] r);
    logic [ROWS-1:0] one;
    one = ROWS'(1);
    return ~(one << r);
  endfunction

  assign row_next   = row + 1'b1;
  assign last_row   = (row == LAST_ROW);
  assign timer_tick = (state != S_LOAD);

  always_comb begin
    timer_load  = 1'b0;
    timer_value = ROW_START_LOAD;
    unique case (state)
      S_LOAD:  timer_load = enable;
      S_BLANK: begin
        timer_load  = timer_done;
        timer_value = DWELL_LOAD;
      end
      S_DRIVE: timer_load = timer_done && !last_row;
      default: timer_load = 1'b0;
    endcase
  end

  scan_timer #(
    .WIDTH(CW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .tick       (timer_tick),
    .done       (timer_done)
  );

  always_ff @(posedge clock) begin
    if ((state == S_LOAD) && enable) begin
      shadow_red <= RedPixels;
      shadow_grn <= GrnPixels;
    end
  end

  // Outputs are set on the edge that enters a phase, so they line up with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_LOAD;
      row         <= '0;
      RowSinks    <= '1;
      RedDriver   <= '0;
      GrnDriver   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      unique case (state)
        S_LOAD: begin
          if (enable) begin
            frame_start <= 1'b1;
            row         <= '0;
            if (BLANK_CYCLES == 0) begin
              // Shadow is loading on this same edge, so take row 0 from the inputs.
              state     <= S_DRIVE;
              RowSinks  <= row_select('0);
              RedDriver <= RedPixels[0];
              GrnDriver <= GrnPixels[0];
            end else begin
              state <= S_BLANK;
            end
          end
        end
        S_BLANK: begin
          if (timer_done) begin
            state     <= S_DRIVE;
            RowSinks  <= row_select(row);
            RedDriver <= shadow_red[row];
            GrnDriver <= shadow_grn[row];
          end
        end
        S_DRIVE: begin
          if (timer_done) begin
            RowSinks  <= '1;
            RedDriver <= '0;
            GrnDriver <= '0;
            if (last_row) begin
              state <= S_LOAD;
            end else begin
              row <= row_next;
              if (BLANK_CYCLES == 0) begin
                RowSinks  <= row_select(row_next);
                RedDriver <= shadow_red[row_next];
                GrnDriver <= shadow_grn[row_next];
              end else begin
                state <= S_BLANK;
              end
            end
          end
        end
        default: begin
          state    <= S_LOAD;
          RowSinks <= '1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
